// File: rtl/rf_pkg.sv
// Shared register-file definitions.
// Holds the default data/address widths, the packed-port slice offset helper
// and the address-validity rule, so decode and the hazard unit agree with the
// register file on which addresses are real registers.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // LSB of port `port` inside a packed bus of `width`-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

  // An address names a writable/reservable register when it is implemented
  // and is not the hardwired zero register.
  function automatic logic rf_addr_ok(input logic [31:0] addr, input int num_regs,
                                      input bit zero_reg);
    return (addr < 32'(num_regs)) && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the register file.
// Ports:
//   clk, reset (async, active-low)
//   wr_en/wr_addr   : a write retires the producer and clears its pending bit
//   rsv_en/rsv_addr : a new producer reserves its destination
//   flush           : clears all pending bits, overrides rsv_en
//   pend            : current pending bits
//   pend_nxt        : pending bits as they will be after this edge (read forwarding)
//   busy_cnt        : number of pending registers
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pend,
  output logic [NUM_REGS-1:0] pend_nxt,
  output logic [ADDR_W:0]     busy_cnt
);

  logic wr_ok;
  logic rsv_ok;
  logic cnt_inc;
  logic cnt_dec;

  assign wr_ok  = wr_en  && rf_addr_ok(32'(wr_addr),  NUM_REGS, ZERO_REG);
  assign rsv_ok = rsv_en && rf_addr_ok(32'(rsv_addr), NUM_REGS, ZERO_REG);

  // Clear is applied before set so a same-address reserve wins: the
  // retiring write is already superseded by a newer producer.
  always_comb begin
    pend_nxt = pend;
    cnt_inc  = 1'b0;
    cnt_dec  = 1'b0;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      if (wr_ok) begin
        pend_nxt[wr_addr] = 1'b0;
        cnt_dec = pend[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));
      end
      if (rsv_ok) begin
        pend_nxt[rsv_addr] = 1'b1;
        cnt_inc = !pend[rsv_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      pend <= pend_nxt;
      if (flush) busy_cnt <= '0;
      else       busy_cnt <= busy_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-to-read bypass and pending scoreboard.
// Ports:
//   clk, reset (async, active-low)
//   rd_en[NUM_RD], rd_addr (packed), rd_data (packed, registered), rd_pend (registered)
//   wr_en, wr_addr, wr_data : single write port
//   rsv_en, rsv_addr, flush : scoreboard control
//   busy_cnt                : number of pending registers
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;
  logic                wr_ok;

  logic [ADDR_W-1:0]   rd_a     [NUM_RD];
  logic [DATA_W-1:0]   data_nxt [NUM_RD];
  logic                rdp_nxt  [NUM_RD];
  logic [DATA_W-1:0]   data_q   [NUM_RD];
  logic                rdp_q    [NUM_RD];

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .pend     (pend),
    .pend_nxt (pend_nxt),
    .busy_cnt (busy_cnt)
  );

  assign wr_ok = wr_en && rf_addr_ok(32'(wr_addr), NUM_REGS, ZERO_REG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read pending is taken from the post-edge scoreboard state, which
  // forwards a same-edge reserve (1), write (0) or flush (0) exactly like
  // the data bypass.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_a[p]     = rd_addr[port_lsb(p, ADDR_W) +: ADDR_W];
      data_nxt[p] = '0;
      rdp_nxt[p]  = 1'b0;
      if (rf_addr_ok(32'(rd_a[p]), NUM_REGS, ZERO_REG)) begin
        if (wr_ok && (wr_addr == rd_a[p])) data_nxt[p] = wr_data;
        else                               data_nxt[p] = mem[rd_a[p]];
        rdp_nxt[p] = pend_nxt[rd_a[p]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_RD; p++) begin
        data_q[p] <= '0;
        rdp_q[p]  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          data_q[p] <= data_nxt[p];
          rdp_q[p]  <= rdp_nxt[p];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[port_lsb(p, DATA_W) +: DATA_W] = data_q[p];
      rd_pend[p] = rdp_q[p];
    end
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with a pending-write scoreboard, the next-generation general-purpose register file for the RISC CPU datapath. It provides NUM_RD registered read ports, one write port with write-to-read bypass, and an optional hardwired zero register. Per-register pending bits let the decode stage detect RAW hazards against in-flight instructions. All state clears on reset; there is no file-based preload.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width
- NUM_REGS, 2**ADDR_W, implemented registers (≤ 2**ADDR_W)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port p at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_pend  out  NUM_RD  registered pending flag of the register read
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve a destination (sets its pending bit)
- rsv_addr  in  ADDR_W  register to reserve
- flush  in  1  clear all pending bits (pipeline flush)
- busy_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- Reset (reset low, asynchronous): all registers = 0; rd_data = 0; rd_pend = 0; pending bits = 0; busy_cnt = 0.
- Write: wr_en high at a rising edge with wr_addr < NUM_REGS stores wr_data. Writes to address 0 with ZERO_REG=1, or to addresses ≥ NUM_REGS, are dropped. A write also clears the pending bit of wr_addr.
- Read port p: rd_en[p] high at a rising edge loads rd_data[p] and rd_pend[p]. When rd_en[p] is low, the port holds its previous value.
- Bypass: if the same edge carries wr_en with wr_addr == rd_addr[p] (valid, non-zero-reg), rd_data[p] = wr_data and rd_pend[p] = 0.
- Reading address ≥ NUM_REGS returns 0 and not pending. Reading register 0 with ZERO_REG=1 returns 0 and not pending.
- Reserve: rsv_en sets pending[rsv_addr], ignored for the zero register or an out-of-range address.
- Simultaneous reserve and write to the same address: the reserve wins, so the bit stays set (new producer). rd_pend bypass then reports 1.
- flush clears every pending bit and takes priority over rsv_en in the same cycle. wr_en data is still written.
- busy_cnt equals the popcount of the pending bits after the edge. It is registered and updated incrementally: +1 for a set, −1 for a clear, 0 on flush. Simultaneous set and clear of different registers leaves it unchanged.
- Reserving an already-pending register does not change busy_cnt.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N.
- Write-to-read, same edge: the new data is visible via bypass.
- Write-to-read, next edge: the new data comes from the array.
- Reserve at edge N: a read at edge N+1 sees pending = 1. A read at the same edge N also reports pending, because the reserve is forwarded like the bypass.
- reset asserted mid-cycle clears all state immediately. Deassertion is synchronised externally; the first operative edge is the first rising edge after deassertion.
- No combinational path exists from any input to any output.

## Structure
- Shared package rf_pkg holds the default DATA_W/ADDR_W constants and the function for packed-port slice offsets, shared with decode and the hazard unit.
- Sub-module regfile_scoreboard contains the pending bits, the reserve/clear/flush priority logic and the busy_cnt counter.
- regfile_mp contains the storage array, the read ports and the bypass muxes.

## Test plan
- Reset and zero register: assert reset with random inputs, then write 0xDEAD_BEEF to reg 0 and read reg 0 -> rd_data = 0, rd_pend = 0, busy_cnt = 0 throughout.
- Basic write and read: write reg 5 = 0x1234_5678, next cycle read reg 5 on both ports -> both ports show 0x1234_5678 one edge later. With rd_en low, the port holds its value while reg 5 is rewritten.
- Bypass: same edge writes reg 7 = 0xA5A5_A5A5 and reads reg 7 on port 1 -> rd_data[1] = 0xA5A5_A5A5 after that edge.
- Scoreboard: reserve regs 3 and 9 -> busy_cnt = 2. Read reg 3 -> rd_pend = 1. Write reg 3 -> busy_cnt = 1, read shows pending 0. Reserve reg 9 and write reg 9 on the same edge -> pending stays 1, busy_cnt = 1.
- Flush and priority: reserve 4 regs, then assert flush with rsv_en on reg 12 -> busy_cnt = 0 and reg 12 not pending. A concurrent write still lands.
- Async reset mid-operation: pull reset low between edges after writes and reserves -> outputs and busy_cnt drop to 0 immediately. After release, reading any register returns 0.
